// File: rtl/cache_ctrl.sv
// Set-associative MESI cache controller: owns per-set tag, MESI and tree-PLRU
// state, sequences one CPU request at a time and answers bus snoops every cycle.
module cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_OFF_W = 6,
    parameter int NUM_SETS   = 16,
    parameter int WAYS       = 4
) (
    input  logic                     clk_i,
    input  logic                     rstb_i,
    input  logic                     cpu_req_valid_i,
    output logic                     cpu_req_ready_o,
    input  logic                     cpu_req_op_i,
    input  logic [ADDR_W-1:0]        cpu_req_addr_i,
    output logic                     cpu_resp_valid_o,
    output logic                     cpu_resp_hit_o,
    output logic [$clog2(WAYS)-1:0]  cpu_resp_way_o,
    output logic                     bus_req_valid_o,
    output logic [1:0]               bus_req_op_o,
    output logic [ADDR_W-1:0]        bus_req_addr_o,
    input  logic                     bus_req_ack_i,
    input  logic                     bus_resp_shared_i,
    input  logic                     snoop_valid_i,
    input  logic [1:0]               snoop_op_i,
    input  logic [ADDR_W-1:0]        snoop_addr_i,
    output logic                     snoop_result_valid_o,
    output logic [1:0]               snoop_result_o
);

    // state   | meaning
    // IDLE    | ready for a CPU request
    // LOOKUP  | tag compare, hit handling or victim choice
    // UPGRADE | INVALIDATE on the bus to take a Shared line to Modified
    // EVICT   | WRITEBACK of a Modified victim
    // FILL    | READ or RFO of the requested line
    // RESP    | one-cycle completion pulse to the CPU

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int TAG_W  = ADDR_W - LINE_OFF_W - IDX_W;
    localparam int PLRU_W = WAYS - 1;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, UPGRADE, EVICT, FILL, RESP} state_e;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit=1 sends the victim to the upper half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
        logic [WAYS-1:0]  tt;
        logic [WAY_W-1:0] w;
        int               node;
        logic             v;
        tt   = {1'b0, t};
        w    = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v    = tt[node[WAY_W-1:0]];
            w    = WAY_W'({w, v});
            node = 2 * node + 1 + int'(v);
        end
        return w;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] t,
                                                      input logic [WAY_W-1:0] way);
        logic [WAYS-1:0]  tt;
        logic [WAY_W-1:0] wsh;
        int               node;
        logic             v;
        tt   = {1'b0, t};
        wsh  = way;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v                    = wsh[WAY_W-1];
            wsh                  = wsh << 1;
            tt[node[WAY_W-1:0]]  = ~v;
            node                 = 2 * node + 1 + int'(v);
        end
        return tt[PLRU_W-1:0];
    endfunction

    logic [TAG_W-1:0]  tag_q  [NUM_SETS][WAYS];
    logic [1:0]        mesi_q [NUM_SETS][WAYS];
    logic [PLRU_W-1:0] plru_q [NUM_SETS];

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic [IDX_W-1:0] req_idx_q, req_idx_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic             hit_q, hit_d;
    logic             snp_valid_q;
    logic [1:0]       snp_res_q;

    logic             lk_hit, lk_inv;
    logic [WAY_W-1:0] lk_hit_way, lk_inv_way, victim_way, wr_way;
    logic [1:0]       lk_state, victim_state, cur_state;
    logic             fsm_mesi_we, fsm_tag_we, plru_we;
    logic [1:0]       fsm_mesi_val;

    logic [TAG_W-1:0] snp_tag;
    logic [IDX_W-1:0] snp_idx;
    logic             snp_hit, snp_we;
    logic [WAY_W-1:0] snp_way;
    logic [1:0]       snp_state, snp_val, snp_res;
    logic             unused_bits;

    assign unused_bits = ^{cpu_req_addr_i[LINE_OFF_W-1:0], snoop_addr_i[LINE_OFF_W-1:0]};

    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        lk_inv     = 1'b0;
        lk_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi_q[req_idx_q][w] != ST_I && tag_q[req_idx_q][w] == req_tag_q) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_W'(w);
            end
            if (mesi_q[req_idx_q][w] == ST_I) begin
                lk_inv     = 1'b1;
                lk_inv_way = WAY_W'(w);
            end
        end
        victim_way   = lk_inv ? lk_inv_way : plru_victim(plru_q[req_idx_q]);
        lk_state     = mesi_q[req_idx_q][lk_hit_way];
        victim_state = mesi_q[req_idx_q][victim_way];
        cur_state    = mesi_q[req_idx_q][way_q];
        wr_way       = (state_q == LOOKUP) ? lk_hit_way : way_q;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        way_d        = way_q;
        hit_d        = hit_q;
        fsm_mesi_we  = 1'b0;
        fsm_mesi_val = ST_I;
        fsm_tag_we   = 1'b0;
        plru_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid_i) begin
                    op_d      = cpu_req_op_i;
                    req_tag_d = cpu_req_addr_i[LINE_OFF_W+IDX_W +: TAG_W];
                    req_idx_d = cpu_req_addr_i[LINE_OFF_W +: IDX_W];
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lk_hit) begin
                    way_d   = lk_hit_way;
                    plru_we = 1'b1;
                    if (op_q && lk_state == ST_S) begin
                        state_d = UPGRADE;
                    end else begin
                        fsm_mesi_we  = op_q;
                        fsm_mesi_val = ST_M;
                        hit_d        = 1'b1;
                        state_d      = RESP;
                    end
                end else begin
                    way_d   = victim_way;
                    hit_d   = 1'b0;
                    state_d = (victim_state == ST_M) ? EVICT : FILL;
                end
            end
            UPGRADE: begin
                if (bus_req_ack_i) begin
                    // A snoop may have invalidated the line while we waited: refetch it.
                    if (cur_state == ST_I) begin
                        hit_d   = 1'b0;
                        state_d = FILL;
                    end else begin
                        fsm_mesi_we  = 1'b1;
                        fsm_mesi_val = ST_M;
                        hit_d        = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            EVICT: begin
                if (bus_req_ack_i) begin
                    fsm_mesi_we  = 1'b1;
                    fsm_mesi_val = ST_I;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (bus_req_ack_i) begin
                    fsm_tag_we   = 1'b1;
                    fsm_mesi_we  = 1'b1;
                    fsm_mesi_val = op_q ? ST_M : (bus_resp_shared_i ? ST_S : ST_E);
                    plru_we      = 1'b1;
                    hit_d        = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snp_tag = snoop_addr_i[LINE_OFF_W+IDX_W +: TAG_W];
        snp_idx = snoop_addr_i[LINE_OFF_W +: IDX_W];
        snp_hit = 1'b0;
        snp_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi_q[snp_idx][w] != ST_I && tag_q[snp_idx][w] == snp_tag) begin
                snp_hit = 1'b1;
                snp_way = WAY_W'(w);
            end
        end
        snp_state = mesi_q[snp_idx][snp_way];
        snp_res   = 2'd0;
        snp_we    = 1'b0;
        snp_val   = ST_I;
        if (snoop_valid_i && snp_hit) begin
            case (snoop_op_i)
                2'd0: begin
                    snp_res = (snp_state == ST_M) ? 2'd2 : 2'd1;
                    snp_we  = (snp_state == ST_M) || (snp_state == ST_E);
                    snp_val = ST_S;
                end
                2'd1, 2'd2: begin
                    snp_res = (snp_state == ST_M) ? 2'd2 : 2'd1;
                    snp_we  = 1'b1;
                    snp_val = ST_I;
                end
                default: snp_res = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstb_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    mesi_q[s][w] <= ST_I;
                end
            end
        end else begin
            if (fsm_tag_we)  tag_q[req_idx_q][wr_way]  <= req_tag_q;
            if (fsm_mesi_we) mesi_q[req_idx_q][wr_way] <= fsm_mesi_val;
            if (plru_we)     plru_q[req_idx_q] <= plru_update(plru_q[req_idx_q], wr_way);
            // Snoop write follows the FSM write so it wins on a same-line collision.
            if (snp_we)      mesi_q[snp_idx][snp_way] <= snp_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstb_i) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            way_q       <= '0;
            hit_q       <= 1'b0;
            snp_valid_q <= 1'b0;
            snp_res_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            way_q       <= way_d;
            hit_q       <= hit_d;
            snp_valid_q <= snoop_valid_i;
            snp_res_q   <= snp_res;
        end
    end

    assign cpu_req_ready_o      = (state_q == IDLE);
    assign cpu_resp_valid_o     = (state_q == RESP);
    assign cpu_resp_hit_o       = (state_q == RESP) && hit_q;
    assign cpu_resp_way_o       = (state_q == RESP) ? way_q : '0;
    assign bus_req_valid_o      = (state_q == UPGRADE) || (state_q == EVICT) || (state_q == FILL);
    assign snoop_result_valid_o = snp_valid_q;
    assign snoop_result_o       = snp_res_q;

    always_comb begin
        bus_req_op_o   = 2'd0;
        bus_req_addr_o = '0;
        case (state_q)
            UPGRADE: begin
                bus_req_op_o   = 2'd3;
                bus_req_addr_o = {req_tag_q, req_idx_q, {LINE_OFF_W{1'b0}}};
            end
            EVICT: begin
                bus_req_op_o   = 2'd2;
                bus_req_addr_o = {tag_q[req_idx_q][way_q], req_idx_q, {LINE_OFF_W{1'b0}}};
            end
            FILL: begin
                bus_req_op_o   = {1'b0, op_q};
                bus_req_addr_o = {req_tag_q, req_idx_q, {LINE_OFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the set-associative MESI cache array. Owns the per-set tag, MESI and tree-PLRU state.
- Accepts one CPU request at a time. On a miss it selects a victim, writes back a Modified victim, then fills, and upgrades Shared lines on writes.
- Services bus snoops every cycle with a registered snoop result.
- Sits between the processor port and the lower-level bus/memory controller.

Parameters:
ADDR_W, 32, byte address width
LINE_OFF_W, 6, line offset bits (64B lines)
NUM_SETS, 16, sets; power of 2; index = addr[LINE_OFF_W +: log2(NUM_SETS)]
WAYS, 4, associativity; power of 2 and >=2; PLRU tree has WAYS-1 bits per set

Ports:
clk  in  1  clock; all logic on posedge
rstb  in  1  reset, synchronous, active-high
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  high in IDLE only; accept = valid & ready
cpu_req_op  in  1  0=read, 1=write
cpu_req_addr  in  ADDR_W  request address
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_resp_hit  out  1  1 = hit (includes S->M upgrade)
cpu_resp_way  out  log2(WAYS)  way that now holds the line
bus_req_valid  out  1  bus request; held until ack
bus_req_op  out  2  0=READ, 1=RFO, 2=WRITEBACK, 3=INVALIDATE
bus_req_addr  out  ADDR_W  line address; offset bits are 0
bus_req_ack  in  1  one-cycle completion
bus_resp_shared  in  1  sampled with ack on READ: another cache holds the line
snoop_valid  in  1  snoop strobe, any cycle
snoop_op  in  2  0=READ, 1=RFO, 2=INVALIDATE, 3=WRITEBACK
snoop_addr  in  ADDR_W  snooped address
snoop_result_valid  out  1  exactly 1 cycle after snoop_valid
snoop_result  out  2  0=NOHIT, 1=HIT, 2=HITM

Behaviour:
- Reset (rstb=1 at a clk edge):
  - All MESI states set to I, tags 0, PLRU bits 0, FSM to IDLE.
  - All registered outputs 0; cpu_req_ready=1 from the first cycle after reset.
  - Reset mid-transaction abandons the transaction and drops bus_req_valid at that edge.
- FSM states: IDLE, LOOKUP, UPGRADE, EVICT, FILL, RESP.
- IDLE:
  - On accept, latch op and address, then go to LOOKUP.
- LOOKUP (1 cycle): hit = any way with state != I and a matching tag.
  - Read hit: go to RESP.
  - Write hit, line E or M: set the line to M, go to RESP.
  - Write hit, line S: go to UPGRADE.
  - Miss, victim selection: the lowest-index way in state I; if none, the PLRU victim.
  - Miss, victim M: go to EVICT. Otherwise go to FILL.
- UPGRADE: drive INVALIDATE for the line.
  - On ack, line still S: set it to M, go to RESP with hit=1.
  - On ack, line already I (a snoop invalidated it): go to FILL as a miss, reusing the same way.
- EVICT: drive WRITEBACK at the victim's line address (victim tag | index). On ack, set the victim to I and go to FILL.
- FILL: drive READ for a CPU read, RFO for a CPU write. On ack:
  - Write the tag.
  - State = M for a write; S for a read with bus_resp_shared=1; E for a read with bus_resp_shared=0.
  - Go to RESP with hit=0.
- RESP:
  - cpu_resp_valid=1 for one cycle, then back to IDLE.
  - Minimum latency: hit = 2 cycles accept-to-resp; miss = ack + 1.
- PLRU:
  - Updated on every CPU hit and every fill at the LOOKUP/ack edge; snoops never touch it.
  - Each tree node on the path is set to point away from the accessed way; bit=0 means the victim lies in the lower half.
  - WAYS=4 encoding: b0 = root, b1 = ways 0/1, b2 = ways 2/3. Access way0 sets b0=1, b1=1.
- Snoop, independent of FSM state:
  - Lookup uses the current arrays; snoop_result is registered.
  - READ: M->S gives HITM; E->S or S gives HIT.
  - RFO or INVALIDATE: the line goes to I; result HITM if the line was M, else HIT.
  - WRITEBACK: no change, result NOHIT.
  - A miss gives NOHIT.
  - A snoop and a FSM write to the same line in the same cycle: the snoop update is applied last.
  - The bus never asserts snoop_valid in the same cycle as bus_req_ack; the bench must not drive both together.
- bus_req_valid, op and addr stay stable until ack. A new request starts no earlier than the cycle after ack.

Test Plan:
1. Reset, read 0x0000_1000 -> READ 0x1000; ack with shared=0 -> resp hit=0 way=0, line E. Re-read -> resp 2 cycles after accept, hit=1, no bus activity.
2. Reads 0x0000, 0x0400, 0x0800, 0x0C00 (all set 0) fill ways 0-3. Read 0x1000 -> PLRU victim way0 (not M), so READ only, resp way=0.
3. Write 0x0000 while the line is E -> line M, no bus request. Then conflicting read 0x1400 with victim way0 -> WRITEBACK 0x0000, then READ 0x1400.
4. Fill 0x2000 with shared=1 (line S), then write 0x2000 -> INVALIDATE 0x2000; ack -> line M, resp hit=1.
5. Snoop READ to an M line -> next cycle HITM, line S. Snoop RFO to that S line -> HIT, line I. Snoop to an absent line -> NOHIT.
6. During UPGRADE, snoop INVALIDATE the same line, then ack -> RFO reissued to the same address, final state M. Separately, reset asserted mid-FILL -> bus_req_valid=0 next cycle and all lines I.
